// File: rtl/hpdmc_wrsched_pkg.sv
// Shared definitions for the HPDMC write-burst sequencer: state encodings,
// DQS ODDR patterns and the idle DM value.
package hpdmc_defs;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    PRE  = 3'd2,
    DATA = 3'd3,
    POST = 3'd4
  } wr_state_t;

  // {dqs_d1, dqs_d2}
  localparam logic [1:0] DQS_PREAMBLE  = 2'b00;
  localparam logic [1:0] DQS_POSTAMBLE = 2'b00;
  localparam logic [1:0] DQS_DATA      = 2'b10;

  // All byte lanes masked.
  localparam logic [3:0] DM_NONE = 4'hF;

endpackage

// File: rtl/hpdmc_downcnt.sv
// Loadable 3-bit down-counter with zero flag. Load has priority over
// decrement; the count saturates at zero.
module hpdmc_downcnt (
  input  logic       sys_clk,
  input  logic       sdram_rst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] count;

  // Count register: load wins, otherwise step down until zero.
  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst)
      count <= 3'd0;
    else if (load)
      count <= load_val;
    else if (dec && (count != 3'd0))
      count <= count - 3'd1;
  end

  assign zero = (count == 3'd0);

endmodule

// File: rtl/hpdmc_wrsched.sv
// HPDMC write-burst sequencer. After an accepted write it waits the write
// latency, then drives DQS preamble, BURST_BEATS data beats and the
// postamble, feeding the DQ/DM/DQS ODDR banks and their output enables.
// Optional build macro HPDMC_WR_UNDERRUN_EN enables the sticky underrun
// flag; without it underrun is tied low (underrun beats are masked anyway).
module hpdmc_wrsched
  import hpdmc_defs::*;
#(
  parameter int unsigned WR_LATENCY  = 1,
  parameter int unsigned BURST_BEATS = 2
) (
  input  logic        sys_clk,
  input  logic        sdram_rst,
  input  logic        write,
  output logic        ready,
  input  logic        wfifo_valid,
  input  logic [63:0] wfifo_d,
  input  logic [7:0]  wfifo_dm,
  output logic        wfifo_ack,
  output logic [31:0] oddr_d1,
  output logic [31:0] oddr_d2,
  output logic [3:0]  dm_d1,
  output logic [3:0]  dm_d2,
  output logic        dqs_d1,
  output logic        dqs_d2,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic        busy,
  output logic        underrun,
  input  logic        underrun_clr
);

  // WR_LATENCY=1 skips WAIT entirely; otherwise WAIT lasts WR_LATENCY-1 cycles.
  localparam logic [2:0] LAT_LOAD  = (WR_LATENCY > 1) ? 3'(WR_LATENCY - 2) : 3'd0;
  localparam logic [2:0] BEAT_LOAD = 3'(BURST_BEATS - 1);
  localparam wr_state_t  START_STATE = (WR_LATENCY == 1) ? PRE : WAIT;

  wr_state_t state;
  logic      accept;
  logic      lat_zero;
  logic      beat_zero;
  logic      beat_ok;
  logic      beat_miss;

  assign accept    = write & ready;
  assign beat_ok   = (state == DATA) & wfifo_valid;
  assign beat_miss = (state == DATA) & ~wfifo_valid;

  hpdmc_downcnt u_lat_cnt (
    .sys_clk   (sys_clk),
    .sdram_rst (sdram_rst),
    .load      (accept && (WR_LATENCY > 1)),
    .load_val  (LAT_LOAD),
    .dec       (state == WAIT),
    .zero      (lat_zero)
  );

  hpdmc_downcnt u_beat_cnt (
    .sys_clk   (sys_clk),
    .sdram_rst (sdram_rst),
    .load      (state == PRE),
    .load_val  (BEAT_LOAD),
    .dec       (state == DATA),
    .zero      (beat_zero)
  );

  // Burst sequencing; a write in POST chains straight into the next burst.
  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= START_STATE;
        WAIT:    if (lat_zero) state <= PRE;
        PRE:     state <= DATA;
        DATA:    if (beat_zero) state <= POST;
        POST:    state <= accept ? START_STATE : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready  = (state == IDLE) || (state == POST);
  assign busy   = (state != IDLE);
  assign dq_oe  = (state == DATA);
  assign dqs_oe = (state == PRE) || (state == DATA) || (state == POST);

  assign {dqs_d1, dqs_d2} = (state == DATA) ? DQS_DATA :
                            (state == POST) ? DQS_POSTAMBLE : DQS_PREAMBLE;

  // A missing word is never retried; the beat goes out fully masked.
  assign wfifo_ack = beat_ok;
  assign oddr_d1   = beat_ok ? wfifo_d[63:32]  : 32'd0;
  assign oddr_d2   = beat_ok ? wfifo_d[31:0]   : 32'd0;
  assign dm_d1     = beat_ok ? wfifo_dm[7:4]   : DM_NONE;
  assign dm_d2     = beat_ok ? wfifo_dm[3:0]   : DM_NONE;

`ifdef HPDMC_WR_UNDERRUN_EN
  logic underrun_q;

  // Sticky underrun flag; a new miss beats a simultaneous clear.
  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst)
      underrun_q <= 1'b0;
    else if (beat_miss)
      underrun_q <= 1'b1;
    else if (underrun_clr)
      underrun_q <= 1'b0;
  end

  assign underrun = underrun_q;
`else
  logic unused_underrun;
  assign unused_underrun = underrun_clr | beat_miss;
  assign underrun        = 1'b0;
`endif

endmodule

// File: tb/tb_hpdmc_wrsched.sv
module tb_hpdmc_wrsched;

  localparam logic [3:0] DMF = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_a = 1'b0, write_b = 1'b0;
  logic        wfifo_valid = 1'b0;
  logic [63:0] wfifo_d = '0;
  logic [7:0]  wfifo_dm = '0;
  logic        underrun_clr = 1'b0;

  logic        ready_a, ack_a, dqs_d1_a, dqs_d2_a, dq_oe_a, dqs_oe_a, busy_a, underrun_a;
  logic [31:0] od1_a, od2_a;
  logic [3:0]  dm1_a, dm2_a;
  logic        ready_b, ack_b, dqs_d1_b, dqs_d2_b, dq_oe_b, dqs_oe_b, busy_b, underrun_b;
  logic [31:0] od1_b, od2_b;
  logic [3:0]  dm1_b, dm2_b;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;

  logic [71:0] fifo_q[$];  // buffer contents {d, dm}
  logic [72:0] exp_q[$];   // expected beat {d1, d2, dm1, dm2, ack}

  always #5 clk = ~clk;

  hpdmc_wrsched #(.WR_LATENCY(1), .BURST_BEATS(2)) dut_a (
    .sys_clk(clk), .sdram_rst(rst), .write(write_a), .ready(ready_a),
    .wfifo_valid(wfifo_valid), .wfifo_d(wfifo_d), .wfifo_dm(wfifo_dm), .wfifo_ack(ack_a),
    .oddr_d1(od1_a), .oddr_d2(od2_a), .dm_d1(dm1_a), .dm_d2(dm2_a),
    .dqs_d1(dqs_d1_a), .dqs_d2(dqs_d2_a), .dq_oe(dq_oe_a), .dqs_oe(dqs_oe_a),
    .busy(busy_a), .underrun(underrun_a), .underrun_clr(underrun_clr)
  );

  hpdmc_wrsched #(.WR_LATENCY(3), .BURST_BEATS(2)) dut_b (
    .sys_clk(clk), .sdram_rst(rst), .write(write_b), .ready(ready_b),
    .wfifo_valid(wfifo_valid), .wfifo_d(wfifo_d), .wfifo_dm(wfifo_dm), .wfifo_ack(ack_b),
    .oddr_d1(od1_b), .oddr_d2(od2_b), .dm_d1(dm1_b), .dm_d2(dm2_b),
    .dqs_d1(dqs_d1_b), .dqs_d2(dqs_d2_b), .dq_oe(dq_oe_b), .dqs_oe(dqs_oe_b),
    .busy(busy_b), .underrun(underrun_b), .underrun_clr(underrun_clr)
  );

  // Scoreboard + write-buffer model, evaluated mid-cycle.
  initial begin
    logic [72:0] e, act;
    forever begin
      @(negedge clk);
      if (!rst && (dq_oe_a || dq_oe_b)) begin
        act = dq_oe_a ? {od1_a, od2_a, dm1_a, dm2_a, ack_a} : {od1_b, od2_b, dm1_b, dm2_b, ack_b};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected actual=%h required=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL beat actual=%h required=%h", act, e);
          end
        end
      end
      if (!rst && (ack_a || ack_b)) begin
        ack_cnt++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      if (fifo_q.size() > 0) begin
        wfifo_valid = 1'b1;
        {wfifo_d, wfifo_dm} = fifo_q[0];
      end else begin
        wfifo_valid = 1'b0;
        wfifo_d = '0;
        wfifo_dm = '0;
      end
    end
  end

  task automatic push_word(input logic [63:0] d, input logic [7:0] dm);
    fifo_q.push_back({d, dm});
    exp_q.push_back({d[63:32], d[31:0], dm[7:4], dm[3:0], 1'b1});
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if ({ready_a, busy_a, dq_oe_a, dqs_oe_a, dqs_d1_a, dqs_d2_a, ack_a, underrun_a} !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_ctrl actual=%b required=10000000",
               {ready_a, busy_a, dq_oe_a, dqs_oe_a, dqs_d1_a, dqs_d2_a, ack_a, underrun_a});
    end
    checks++;
    if ({od1_a, od2_a, dm1_a, dm2_a} !== {64'd0, DMF, DMF}) begin
      errors++;
      $display("FAIL reset_data actual=%h required=%h", {od1_a, od2_a, dm1_a, dm2_a}, {64'd0, DMF, DMF});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    ack_cnt = 0;
    push_word(64'hDEADBEEF_01234567, 8'h00);
    push_word(64'hCAFEF00D_89ABCDEF, 8'h00);
    @(negedge clk);
    write_a = 1'b1;
    @(negedge clk);  // t0+1
    write_a = 1'b0;
    checks++;
    if ({dqs_oe_a, dq_oe_a, ready_a, busy_a, dqs_d1_a, dqs_d2_a} !== 6'b100100) begin
      errors++;
      $display("FAIL basic_pre actual=%b required=100100", {dqs_oe_a, dq_oe_a, ready_a, busy_a, dqs_d1_a, dqs_d2_a});
    end
    @(negedge clk);  // t0+2 DATA
    #2;
    checks++;
    if ({dqs_d1_a, dqs_d2_a, dq_oe_a, ready_a} !== 4'b1010) begin
      errors++;
      $display("FAIL basic_data_dqs actual=%b required=1010", {dqs_d1_a, dqs_d2_a, dq_oe_a, ready_a});
    end
    repeat (2) @(negedge clk);  // t0+4 POST
    checks++;
    if ({dqs_oe_a, dq_oe_a, ready_a, busy_a, dqs_d1_a, dqs_d2_a} !== 6'b101100) begin
      errors++;
      $display("FAIL basic_post actual=%b required=101100", {dqs_oe_a, dq_oe_a, ready_a, busy_a, dqs_d1_a, dqs_d2_a});
    end
    @(negedge clk);  // t0+5 IDLE
    #2;
    checks++;
    if ({busy_a, dqs_oe_a, ack_cnt, exp_q.size()} !== {2'b00, 32'd2, 32'd0}) begin
      errors++;
      $display("FAIL basic_end actual=busy%b dqs_oe%b acks%0d pending%0d required=busy0 dqs_oe0 acks2 pending0",
               busy_a, dqs_oe_a, ack_cnt, exp_q.size());
    end
  endtask

  task automatic test_latency;
    logic [1:0] seen[5];
    logic [1:0] want[5];
    want = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b11};  // {dqs_oe, dq_oe} at t0+0..t0+4
    ack_cnt = 0;
    push_word(64'h11112222_33334444, 8'h0F);
    push_word(64'h55556666_77778888, 8'hA5);
    write_b = 1'b1;
    @(negedge clk);
    write_b = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      seen[i] = {dqs_oe_b, dq_oe_b};
      checks++;
      if (seen[i] !== want[i] || busy_b !== 1'b1) begin
        errors++;
        $display("FAIL latency_t%0d actual=oe%b busy%b required=oe%b busy1", i, seen[i], busy_b, want[i]);
      end
      if (i < 4) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if ({busy_b, ack_cnt} !== {1'b0, 32'd2}) begin
      errors++;
      $display("FAIL latency_end actual=busy%b acks%0d required=busy0 acks2", busy_b, ack_cnt);
    end
  endtask

  task automatic test_back_to_back;
    int drops = 0;
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) push_word({32'hB0B0_0000 + 32'(i), 32'h0000_1000 * 32'(i + 1)}, 8'(i * 17));
    write_a = 1'b1;
    @(negedge clk);  // t0+1
    write_a = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      if (!dqs_oe_a) drops++;
      if (t == 4) begin
        write_a = 1'b1;  // in POST, sampled at its closing edge
        @(negedge clk);
        write_a = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (drops !== 0) begin
      errors++;
      $display("FAIL b2b_dqs_oe actual=%0d_low_cycles required=0", drops);
    end
    #2;
    checks++;
    if ({dqs_oe_a, busy_a, ack_cnt, exp_q.size()} !== {2'b00, 32'd4, 32'd0}) begin
      errors++;
      $display("FAIL b2b_end actual=dqs_oe%b busy%b acks%0d pending%0d required=0 0 4 0",
               dqs_oe_a, busy_a, ack_cnt, exp_q.size());
    end
  endtask

  task automatic test_underrun;
    logic want_ur;
`ifdef HPDMC_WR_UNDERRUN_EN
    want_ur = 1'b1;
`else
    want_ur = 1'b0;
`endif
    ack_cnt = 0;
    push_word(64'h0BADF00D_FEEDFACE, 8'h3C);
    exp_q.push_back({64'd0, DMF, DMF, 1'b0});  // starved beat: masked, no ack
    @(negedge clk);
    write_a = 1'b1;
    @(negedge clk);
    write_a = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    checks++;
    if ({underrun_a, ack_cnt, exp_q.size()} !== {want_ur, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL underrun_set actual=ur%b acks%0d pending%0d required=ur%b acks1 pending0",
               underrun_a, ack_cnt, exp_q.size(), want_ur);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (underrun_a !== want_ur) begin
      errors++;
      $display("FAIL underrun_sticky actual=%b required=%b", underrun_a, want_ur);
    end
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    checks++;
    if (underrun_a !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clr actual=%b required=0", underrun_a);
    end
  endtask

  task automatic test_ignored_write;
    int falls = 0;
    logic prev_busy = 1'b0;
    ack_cnt = 0;
    push_word(64'h12345678_9ABCDEF0, 8'h81);
    push_word(64'h0FEDCBA9_87654321, 8'h18);
    write_b = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      write_b = (t == 1) || (t == 4);  // t0+1 is WAIT, t0+4 is DATA
      if (prev_busy && !busy_b) falls++;
      prev_busy = busy_b;
    end
    write_b = 1'b0;
    checks++;
    if ({falls, ack_cnt, exp_q.size()} !== {32'd1, 32'd2, 32'd0}) begin
      errors++;
      $display("FAIL ignored_write actual=falls%0d acks%0d pending%0d required=falls1 acks2 pending0",
               falls, ack_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_data;
    push_word(64'hAAAA5555_5555AAAA, 8'h00);
    push_word(64'h01010101_10101010, 8'h00);
    @(negedge clk);
    write_a = 1'b1;
    @(negedge clk);  // PRE
    write_a = 1'b0;
    @(negedge clk);  // first DATA
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({dq_oe_a, dqs_oe_a, dm1_a, dm2_a, ack_a} !== {2'b00, DMF, DMF, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_data actual=%b required=%b", {dq_oe_a, dqs_oe_a, dm1_a, dm2_a, ack_a},
               {2'b00, DMF, DMF, 1'b0});
    end
    fifo_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready_a, busy_a} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release actual=ready%b busy%b required=ready1 busy0", ready_a, busy_a);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_latency;
    test_back_to_back;
    test_underrun;
    test_ignored_write;
    test_reset_mid_data;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hpdmc_wrsched.md
Name: hpdmc_wrsched

Overview:
- Write-burst sequencer for the HPDMC DDR data path.
- On a write command from the command scheduler, it waits the write latency, then emits the DQS preamble, the data beats and the postamble.
- Each data beat pulls one 64-bit word from the write buffer and splits it into rising/falling 32-bit halves for the 32-bit ODDR data bank. It does the same for the DM and DQS ODDR banks.
- Generates all DQ/DQS output enables.

Parameters:
- WR_LATENCY, 1, sys_clk cycles from write acceptance to the PRE state. Legal range 1..7.
- BURST_BEATS, 2, data cycles per burst (BL/2). Legal range 1..4.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sdram_rst  in  1  asynchronous, active-high reset
- write  in  1  write-burst request pulse
- ready  out  1  write is accepted this cycle when high
- wfifo_valid  in  1  write buffer holds a word
- wfifo_d  in  64  [63:32] rising half, [31:0] falling half
- wfifo_dm  in  8  [7:4] rising-half mask, [3:0] falling-half mask
- wfifo_ack  out  1  word consumed this cycle
- oddr_d1  out  32  DQ rising-edge data
- oddr_d2  out  32  DQ falling-edge data
- dm_d1  out  4  DM rising-edge data
- dm_d2  out  4  DM falling-edge data
- dqs_d1  out  1  DQS rising-edge data
- dqs_d2  out  1  DQS falling-edge data
- dq_oe  out  1  DQ/DM output enable
- dqs_oe  out  1  DQS output enable
- busy  out  1  state is not IDLE
- underrun  out  1  sticky buffer-underrun flag
- underrun_clr  in  1  clears underrun

Behaviour:
- States: IDLE, WAIT, PRE, DATA, POST; binary-encoded state register. All outputs are decoded from the state register, except wfifo_ack, oddr_*, dm_* (see DATA).
- Reset (async, any state): state=IDLE, counters=0, underrun=0. Outputs go immediately to the IDLE values: dq_oe=0, dqs_oe=0, dqs_d1=dqs_d2=0, oddr_*=0, dm_*=4'hF, wfifo_ack=0, ready=1, busy=0.
- ready = 1 in IDLE or POST, 0 otherwise. write while ready=0 is ignored, with no side effect.
- Acceptance: write and ready. The next state is PRE if WR_LATENCY=1. Otherwise it is WAIT with a latency counter loaded with WR_LATENCY-2.
- WAIT: the counter decrements each cycle. At 0, go to PRE. All enables are 0.
- PRE: one cycle. dqs_oe=1, dqs_d1=dqs_d2=0, dq_oe=0. Load the beat counter with BURST_BEATS-1. Go to DATA.
- DATA:
  - dq_oe=1, dqs_oe=1, dqs_d1=1, dqs_d2=0.
  - When wfifo_valid=1: wfifo_ack=1 (combinational), oddr_d1=wfifo_d[63:32], oddr_d2=wfifo_d[31:0], dm_d1=wfifo_dm[7:4], dm_d2=wfifo_dm[3:0].
  - When wfifo_valid=0 (underrun beat): wfifo_ack=0, oddr_*=0, dm_*=4'hF (the beat is masked), underrun is set.
  - The beat counter decrements. At 0, go to POST.
  - The burst length never stretches; a missing word is never retried.
- POST: one cycle. dqs_oe=1, dqs_d1=dqs_d2=0, dq_oe=0.
  - write in POST is accepted: next state is PRE (WR_LATENCY=1) or WAIT. dqs_oe then stays high across POST→PRE for a seamless back-to-back write.
  - Otherwise, go to IDLE.
- Outside DATA: oddr_*=0, dm_*=4'hF, wfifo_ack=0.
- Outside PRE, DATA, POST: dqs_oe=0.
- underrun_clr clears underrun. If underrun_clr and a new underrun beat occur in the same cycle, set wins.
- Latency example (WR_LATENCY=1, BURST_BEATS=2), write sampled at edge t0:
  - t0+1: PRE
  - t0+2, t0+3: DATA
  - t0+4: POST
  - t0+5: IDLE

Optional Feature:
- Macro: HPDMC_WR_UNDERRUN_EN.
- Defined: underrun detection, sticky flag and underrun_clr are as described above.
- Undefined: the underrun output is tied to 0 and underrun_clr is unused. Underrun beats are still masked (dm_*=4'hF, oddr_*=0); masking is mandatory in both builds.

Decomposition:
- Shared package hpdmc_defs holds:
  - state encodings (IDLE=0, WAIT=1, PRE=2, DATA=3, POST=4)
  - DQS pattern constants (preamble/postamble 2'b00, data 2'b10)
  - DM_NONE=4'hF
- One sub-module, hpdmc_downcnt: loadable 3-bit down-counter with zero flag and async reset. It is instantiated twice, for latency and for beats.
- ODDR banks are instantiated by the parent, not inside this block.

Test Plan:
- Reset mid-DATA: assert sdram_rst in the first DATA cycle → dq_oe=0, dqs_oe=0 and dm_*=4'hF immediately; ready=1 after release.
- Basic burst, WR_LATENCY=1, BURST_BEATS=2, buffer holds 64'hDEADBEEF_01234567 then 64'hCAFEF00D_89ABCDEF with dm 8'h00:
  - PRE at t0+1.
  - t0+2: oddr_d1=32'hDEADBEEF, oddr_d2=32'h01234567.
  - t0+3: oddr_d1=32'hCAFEF00D, oddr_d2=32'h89ABCDEF.
  - Two acks total; POST at t0+4; IDLE at t0+5.
- Latency sweep, WR_LATENCY=3: write at t0 → WAIT at t0+1 and t0+2, PRE at t0+3, first DATA at t0+4.
- Back-to-back: second write in the POST cycle → PRE on the next cycle. dqs_oe stays 1 continuously across both bursts; 4 acks total.
- Underrun: wfifo_valid=0 in the second beat → that beat has dm_d1=dm_d2=4'hF and wfifo_ack=0; underrun=1 until underrun_clr. With HPDMC_WR_UNDERRUN_EN undefined, underrun stays 0 but the beat is still masked.
- Ignored write: pulse write during WAIT or DATA → no state change and no extra burst; busy drops exactly once at burst end.
